// File: rtl/eBike_pkg.sv
// Shared eBike definitions for the A2D round-robin scheduler: FSM states,
// channel-order constants and the SPI command word builder.
package eBike_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WCMD,
    GAP,
    RD,
    WRD,
    FIN
  } a2d_st_t;

  localparam logic [10:0] A2D_CMD_PAD = 11'h000;

  // A2D mux channel numbers as wired on the board
  localparam logic [2:0] A2D_CH_BATT   = 3'd0;
  localparam logic [2:0] A2D_CH_CURR   = 3'd1;
  localparam logic [2:0] A2D_CH_BRAKE  = 3'd3;
  localparam logic [2:0] A2D_CH_TORQUE = 3'd4;

  // Position of each channel within a round
  localparam logic [1:0] IDX_BATT   = 2'd0;
  localparam logic [1:0] IDX_CURR   = 2'd1;
  localparam logic [1:0] IDX_BRAKE  = 2'd2;
  localparam logic [1:0] IDX_TORQUE = 2'd3;

  function automatic logic [15:0] a2d_cmd_word(input logic [2:0] ch);
    return {2'b00, ch, A2D_CMD_PAD};
  endfunction

endpackage

// File: rtl/a2d_smpl_tmr.sv
// Free-running sample timer; a wrap raises pend, which stays set until the
// scheduler consumes it. Several wraps collapse into one pending round.
module a2d_smpl_tmr #(
  parameter int SAMPLE_PER = 16384
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_pend,
  output logic pend
);

  localparam int TW = $clog2(SAMPLE_PER);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_PER - 1);

  logic [TW-1:0] tmr_q;
  logic          pend_q;
  logic          wrap;

  assign wrap = (tmr_q == LAST);
  // The wrap cycle itself already counts as pending so the round can start
  // on the very next clock.
  assign pend = pend_q | wrap;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= wrap ? '0 : tmr_q + 1'b1;
      pend_q <= (pend_q | wrap) & ~clr_pend;
    end
  end

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler: each sample period it runs a
// command/read SPI pair per channel and latches the 12-bit results.
module a2d_rr_sched
  import eBike_pkg::*;
#(
  parameter int         SAMPLE_PER = 16384,
  parameter logic [2:0] CH_BATT    = A2D_CH_BATT,
  parameter logic [2:0] CH_CURR    = A2D_CH_CURR,
  parameter logic [2:0] CH_BRAKE   = A2D_CH_BRAKE,
  parameter logic [2:0] CH_TORQUE  = A2D_CH_TORQUE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        rnd_vld,
  output logic        busy
);

  a2d_st_t    state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] ch_sel;
  logic       pend;
  logic       clr_pend;
  logic       ld_res;
  logic       unused_rd_hi;

  a2d_smpl_tmr #(
    .SAMPLE_PER(SAMPLE_PER)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_pend(clr_pend),
    .pend    (pend)
  );

  // The A2D returns status in the top nibble; only the 12-bit result is kept.
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    ch_sel = CH_BATT;
    unique case (idx_q)
      IDX_BATT:   ch_sel = CH_BATT;
      IDX_CURR:   ch_sel = CH_CURR;
      IDX_BRAKE:  ch_sel = CH_BRAKE;
      IDX_TORQUE: ch_sel = CH_TORQUE;
      default:    ch_sel = CH_BATT;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_pend = 1'b0;
    ld_res   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend) begin
          clr_pend = 1'b1;
          idx_d    = IDX_BATT;
          state_d  = CMD;
        end
      end
      CMD:  state_d = WCMD;
      WCMD: if (done) state_d = GAP;
      GAP:  state_d = RD;
      RD:   state_d = WRD;
      WRD: begin
        if (done) begin
          ld_res = 1'b1;
          if (idx_q == IDX_TORQUE) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = CMD;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_BATT;
      wrt     <= 1'b0;
      cmd     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrt     <= (state_q == CMD) || (state_q == RD);
      // Read reuses the command word so the A2D mux stays on the same channel.
      if ((state_q == CMD) || (state_q == RD)) begin
        cmd <= a2d_cmd_word(ch_sel);
      end
    end
  end

  // NOTE: the result registers are visible outputs that must read 0 after
  // reset, so unlike a plain data store they are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt   <= '0;
      curr   <= '0;
      brake  <= '0;
      torque <= '0;
    end else if (ld_res) begin
      unique case (idx_q)
        IDX_BATT:   batt   <= rd_data[11:0];
        IDX_CURR:   curr   <= rd_data[11:0];
        IDX_BRAKE:  brake  <= rd_data[11:0];
        IDX_TORQUE: torque <= rd_data[11:0];
        default:    batt   <= rd_data[11:0];
      endcase
    end
  end

  assign rnd_vld = (state_q == FIN);
  assign busy    = (state_q != IDLE) && (state_q != FIN);

endmodule

// File: doc/a2d_rr_sched.md
# a2d_rr_sched

Round-robin conversion scheduler for the off-board A2D that senses battery voltage, motor current, brake lever and pedal torque. It sits between the shared A2D SPI master and the sensor-conditioning logic inside eBike. It issues a conversion round across four channels every sample period, moves each 12-bit result into a dedicated holding register, and strobes when a full round is fresh. Only this block drives the A2D SPI master.

## Interface
- SAMPLE_PER, 16384: clocks between round starts; minimum 256.
- CH_BATT, 3'd0: A2D channel number for battery.
- CH_CURR, 3'd1: A2D channel number for motor current.
- CH_BRAKE, 3'd3: A2D channel number for brake lever.
- CH_TORQUE, 3'd4: A2D channel number for torque sensor.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- wrt  out  1  one-clock pulse; starts one 16-bit SPI transaction.
- cmd  out  16  SPI transmit word; held stable from the wrt pulse until done.
- done  in  1  one-clock pulse from the SPI master; transaction finished.
- rd_data  in  16  SPI receive word; valid in the cycle done is high.
- batt  out  12  latest battery sample.
- curr  out  12  latest current sample.
- brake  out  12  latest brake sample.
- torque  out  12  latest torque sample.
- rnd_vld  out  1  one-clock pulse; all four registers updated this round.
- busy  out  1  high from round start until rnd_vld.

## Operation
- Sample timer is free-running and sized $clog2(SAMPLE_PER). It wraps at SAMPLE_PER-1. The wrap sets the pend flag.
- Channel order is fixed: BATT, CURR, BRAKE, TORQUE. A 2-bit index selects the channel, and the index resets to 0 at each round start.
- Each channel takes two SPI transactions:
  - Command transaction: cmd = {2'b00, ch[2:0], 11'h000}. The received data is discarded.
  - Read transaction: cmd = the same word, so the A2D keeps the same channel. The result is rd_data[11:0]; rd_data[15:12] is ignored.
- States:
  - IDLE: when pend is set, clear pend, set index to 0, go to CMD.
  - CMD: pulse wrt, go to WCMD.
  - WCMD: on done, go to GAP.
  - GAP: wait one clock, go to RD. This satisfies the A2D SS_n high time.
  - RD: pulse wrt, go to WRD.
  - WRD: on done, write rd_data[11:0] into the indexed register. If index is 3, go to FIN; otherwise increment the index and go to CMD.
  - FIN: pulse rnd_vld, go to IDLE.
- A timer wrap while busy only sets pend. Multiple wraps collapse into one pending round; no round is queued twice.
- A done pulse in IDLE, CMD, GAP, RD or FIN is ignored.
- A register changes only in the cycle its read-transaction done arrives. Consumers never see a partially updated register.
- Reset at any point: return to IDLE; clear pend, index and timer; set every output to 0. An SPI transaction in flight is abandoned. The SPI master is reset by the same rst_n.

## Timing
- Reset values are 0 for wrt, cmd, batt, curr, brake, torque, rnd_vld and busy.
- The first round starts SAMPLE_PER clocks after reset deasserts. pend rises at timer = SAMPLE_PER-1, and the state is CMD on the next clock.
- wrt goes high the clock after entering CMD or RD, and lasts exactly one clock.
- A register is updated at the clock edge ending the done cycle.
- rnd_vld is asserted one clock after the TORQUE done. busy drops in the same cycle that rnd_vld is high.
- Round length = 8×T_spi + 4 (GAP) + 8 (CMD/RD state) + 2 clocks, where T_spi is the SPI master's wrt-to-done latency. SAMPLE_PER must exceed this.

## Structure
- Shared package eBike_pkg holds:
  - the state enum a2d_st_t (IDLE, CMD, WCMD, GAP, RD, WRD, FIN);
  - localparam A2D_CMD_PAD = 11'h000;
  - the channel-order constants.
- Sub-module a2d_smpl_tmr is the natural split: timer plus pend flag, with inputs clr_pend and outputs pend.
- The result registers and FSM stay in a2d_rr_sched.

## Test plan
- SPI responder: T_spi = 40, returns 16'hF000 | (ch<<8) | 8'h5A. Required: rounds start at SAMPLE_PER; cmd sequence 0x0000, 0x0000, 0x0800, 0x0800, 0x1800, 0x1800, 0x2000, 0x2000; batt=0x05A, curr=0x15A, brake=0x35A, torque=0x45A; upper nibble dropped.
- Counts per round: exactly 8 wrt pulses, one rnd_vld, busy high through the round.
- SAMPLE_PER = 256 with T_spi = 40: all rounds run back-to-back. Force one round longer than two periods with a slow responder: exactly one extra round follows, not two.
- Spurious done in IDLE and GAP: no register changes and no state advance.
- rst_n low in the middle of the CURR read: all outputs read 0 asynchronously. After release, the next round starts SAMPLE_PER clocks later and begins with BATT.
- Change the value the responder returns for brake between rounds: the new value appears in the brake register only, at the brake done edge; the other registers keep their values.
